// File: rtl/msi_pkg.sv
// msi_pkg: shared MSI bus message and transaction-state encodings
package msi_pkg;
  typedef enum logic [1:0] {MSG_NONE, MSG_BUSRD, MSG_BUSRDX, MSG_BUSUPGR} msg_e;
  typedef enum logic [2:0] {IDLE, ADDR, SNOOP, MEM, DONE} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_i+1
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] k;
  always_comb begin
    idx_o = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(last_i) + i) % N);
      if (req_i[k]) idx_o = k;
    end
    gnt_o = (|req_i) ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin snoopy MSI bus arbiter and transaction sequencer
module snoop_bus_ctrl
  import msi_pkg::*;
#(
  parameter int NUM_PROCS    = 4,
  parameter int ADDR_SIZE    = 2,
  parameter int SNOOP_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PROCS-1:0]           req_i,
  input  logic [2*NUM_PROCS-1:0]         msg_i,
  input  logic [ADDR_SIZE*NUM_PROCS-1:0] addr_i,
  input  logic [NUM_PROCS-1:0]           flush_i,
  input  logic                           mem_ack_i,
  output logic [NUM_PROCS-1:0]           gnt_o,
  output logic                           bus_valid_o,
  output logic [1:0]                     bus_msg_o,
  output logic [ADDR_SIZE-1:0]           bus_addr_o,
  output logic [$clog2(NUM_PROCS)-1:0]   bus_owner_o,
  output logic                           flush_o,
  output logic                           mem_req_o,
  output logic [NUM_PROCS-1:0]           done_o,
  output logic                           err_flush_o,
  output logic                           err_timeout_o
);
  localparam int OW = $clog2(NUM_PROCS);
  localparam int CW = $clog2((SNOOP_CYCLES > MEM_TIMEOUT ? SNOOP_CYCLES : MEM_TIMEOUT) + 1);
  state_e                state_q, state_d;
  msg_e                  msg_q, msg_d;
  logic [OW-1:0]         owner_q, owner_d, last_q, last_d, arb_idx;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [NUM_PROCS-1:0]  fl_q, fl_d, arb_gnt, own_oh, masked;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_fl_q, err_fl_d, err_to_q, err_to_d;
  rr_arbiter #(.N(NUM_PROCS)) u_arb (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );
  assign own_oh = NUM_PROCS'(1) << owner_q;
  assign masked = flush_i & ~own_oh;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      msg_q    <= MSG_NONE;
      owner_q  <= '0;
      last_q   <= OW'(NUM_PROCS - 1);
      addr_q   <= '0;
      fl_q     <= '0;
      cnt_q    <= '0;
      err_fl_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      fl_q     <= fl_d;
      cnt_q    <= cnt_d;
      err_fl_q <= err_fl_d;
      err_to_q <= err_to_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    fl_d     = fl_q;
    cnt_d    = cnt_q;
    err_fl_d = err_fl_q;
    err_to_d = err_to_q;
    case (state_q)
      IDLE: if (|arb_gnt) begin
        owner_d = arb_idx;
        msg_d   = msg_e'(msg_i[2*arb_idx +: 2]);
        addr_d  = addr_i[ADDR_SIZE*arb_idx +: ADDR_SIZE];
        state_d = ADDR;
      end
      ADDR: begin
        cnt_d   = '0;
        state_d = msg_q == MSG_NONE ? DONE : SNOOP;
      end
      SNOOP: begin
        fl_d = fl_q | masked;
        // two or more non-owner flushers in one cycle is a protocol error
        if ((masked & (masked - NUM_PROCS'(1))) != '0) err_fl_d = 1'b1;
        if (cnt_q == CW'(SNOOP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (|fl_d) ? DONE : msg_q == MSG_BUSUPGR ? DONE : MEM;
        end else cnt_d = cnt_q + CW'(1);
      end
      MEM: begin
        if (mem_ack_i) state_d = DONE;
        else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = DONE;
        end else cnt_d = cnt_q + CW'(1);
      end
      DONE: begin
        last_d  = owner_q;
        fl_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    gnt_o         = state_q == ADDR ? own_oh : '0;
    bus_valid_o   = state_q == ADDR;
    bus_msg_o     = bus_valid_o ? msg_q : MSG_NONE;
    bus_addr_o    = bus_valid_o ? addr_q : '0;
    bus_owner_o   = owner_q;
    flush_o       = state_q == DONE && |fl_q;
    mem_req_o     = state_q == MEM;
    done_o        = state_q == DONE ? own_oh : '0;
    err_flush_o   = err_fl_q;
    err_timeout_o = err_to_q;
  end
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed scenario bench for snoop_bus_ctrl
module tb_snoop_bus_ctrl;
  logic       clk_i = 1'b0, rst_i = 1'b1, mem_ack_i = 1'b0;
  logic [3:0] req_i = '0, flush_i = '0;
  logic [7:0] msg_i = '0, addr_i = '0;
  logic [3:0] gnt_o, done_o;
  logic [1:0] bus_msg_o, bus_addr_o, bus_owner_o;
  logic       bus_valid_o, flush_o, mem_req_o, err_flush_o, err_timeout_o;
  int checks = 0, fails = 0;
  snoop_bus_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .msg_i(msg_i), .addr_i(addr_i),
    .flush_i(flush_i), .mem_ack_i(mem_ack_i), .gnt_o(gnt_o), .bus_valid_o(bus_valid_o),
    .bus_msg_o(bus_msg_o), .bus_addr_o(bus_addr_o), .bus_owner_o(bus_owner_o),
    .flush_o(flush_o), .mem_req_o(mem_req_o), .done_o(done_o),
    .err_flush_o(err_flush_o), .err_timeout_o(err_timeout_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset;
    rst_i = 1'b1; req_i = '0; msg_i = '0; addr_i = '0; flush_i = '0; mem_ack_i = 1'b0;
    cyc;
    cyc;
    rst_i = 1'b0;
  endtask
  task automatic test_reset;
    logic [22:0] got;
    do_reset;
    got = {gnt_o, done_o, bus_valid_o, bus_msg_o, bus_addr_o, bus_owner_o, flush_o, mem_req_o, err_flush_o, err_timeout_o};
    checks++;
    if (got !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", got); end
  endtask
  task automatic test_round_robin;
    int gc[8];
    int ng = 0, nd = 0, mcnt = 0;
    logic [3:0] exp_oh;
    do_reset;
    req_i = 4'hF; msg_i = 8'h55; addr_i = 8'b11_10_01_00;
    for (int c = 0; c < 48; c++) begin
      cyc;
      mcnt = mem_req_o ? mcnt + 1 : 0;
      mem_ack_i = (mcnt == 4);
      if (|gnt_o) begin
        exp_oh = 4'b0001 << (ng % 4);
        checks++;
        if (gnt_o !== exp_oh || bus_addr_o !== 2'(ng % 4) || bus_msg_o !== 2'b01 || !bus_valid_o) begin
          fails++; $display("FAIL rr_grant%0d: gnt %b addr %b msg %b want gnt %b addr %0d msg 01", ng, gnt_o, bus_addr_o, bus_msg_o, exp_oh, ng % 4);
        end
        if (ng < 8) gc[ng] = c;
        ng++;
      end
      if (|done_o) begin
        exp_oh = 4'b0001 << (nd % 4);
        checks++;
        if (nd >= ng || done_o !== exp_oh || c != gc[nd] + 6) begin
          fails++; $display("FAIL rr_done%0d: done %b at cycle %0d want %b at gnt+6", nd, done_o, c, exp_oh);
        end
        nd++;
      end
    end
    checks++;
    if (ng < 5 || nd < 4) begin fails++; $display("FAIL rr_count: grants %0d dones %0d want >=5 >=4", ng, nd); end
    req_i = '0; mem_ack_i = 1'b0;
  endtask
  task automatic test_flush_rdx;
    do_reset;
    req_i = 4'b0100; msg_i = 8'b00_10_00_00; addr_i = 8'b00_11_00_00;
    cyc;
    checks++;
    if (gnt_o !== 4'b0100 || bus_addr_o !== 2'b11 || bus_msg_o !== 2'b10 || !bus_valid_o || bus_owner_o !== 2'd2) begin
      fails++; $display("FAIL rdx_addr: gnt %b addr %b msg %b owner %0d want 0100 11 10 2", gnt_o, bus_addr_o, bus_msg_o, bus_owner_o);
    end
    req_i = '0; flush_i = 4'b0110;
    cyc;
    checks++;
    if (mem_req_o !== 1'b0 || done_o !== 4'b0000) begin fails++; $display("FAIL rdx_snoop: mem_req %b done %b want 0 0000", mem_req_o, done_o); end
    cyc;
    flush_i = '0;
    checks++;
    if (done_o !== 4'b0100 || flush_o !== 1'b1 || mem_req_o !== 1'b0 || err_flush_o !== 1'b0 || bus_owner_o !== 2'd2) begin
      fails++; $display("FAIL rdx_done: done %b flush %b mem_req %b err_flush %b owner %0d want 0100 1 0 0 2", done_o, flush_o, mem_req_o, err_flush_o, bus_owner_o);
    end
    cyc;
    checks++;
    if (done_o !== 4'b0000 || flush_o !== 1'b0 || bus_owner_o !== 2'd2) begin
      fails++; $display("FAIL rdx_idle: done %b flush %b owner %0d want 0000 0 2", done_o, flush_o, bus_owner_o);
    end
  endtask
  task automatic test_upgrade;
    do_reset;
    req_i = 4'b0001; msg_i = 8'b00_00_00_11;
    cyc;
    req_i = '0;
    checks++;
    if (gnt_o !== 4'b0001 || bus_msg_o !== 2'b11) begin fails++; $display("FAIL upgr_gnt: gnt %b msg %b want 0001 11", gnt_o, bus_msg_o); end
    cyc;
    cyc;
    checks++;
    if (done_o !== 4'b0001 || mem_req_o !== 1'b0 || flush_o !== 1'b0) begin
      fails++; $display("FAIL upgr_done: done %b mem_req %b flush %b want 0001 0 0", done_o, mem_req_o, flush_o);
    end
  endtask
  task automatic test_multi_flush;
    do_reset;
    req_i = 4'b0001; msg_i = 8'h01;
    cyc;
    req_i = '0; flush_i = 4'b0111;
    cyc;
    cyc;
    flush_i = '0;
    checks++;
    if (err_flush_o !== 1'b1 || flush_o !== 1'b1 || done_o !== 4'b0001) begin
      fails++; $display("FAIL mflush_done: err_flush %b flush %b done %b want 1 1 0001", err_flush_o, flush_o, done_o);
    end
    repeat (5) cyc;
    checks++;
    if (err_flush_o !== 1'b1) begin fails++; $display("FAIL mflush_sticky: err_flush %b want 1", err_flush_o); end
    do_reset;
    checks++;
    if (err_flush_o !== 1'b0) begin fails++; $display("FAIL mflush_clear: err_flush %b want 0", err_flush_o); end
  endtask
  task automatic test_timeout(input bit ack_last);
    int mc = 0;
    bit seen = 0;
    do_reset;
    req_i = 4'b0001; msg_i = 8'h01;
    cyc;
    req_i = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cyc;
      if (mem_req_o) mc++;
      mem_ack_i = ack_last && mem_req_o && mc == 15;
      seen = |done_o;
    end
    mem_ack_i = 1'b0;
    checks++;
    if (!seen || mc != 15 || done_o !== 4'b0001 || err_timeout_o !== !ack_last) begin
      fails++; $display("FAIL timeout_ack%0d: seen %0d mem_cycles %0d done %b err_to %b want 1 15 0001 %b", ack_last, seen, mc, done_o, err_timeout_o, !ack_last);
    end
    cyc;
    checks++;
    if (done_o !== 4'b0000 || mem_req_o !== 1'b0 || err_timeout_o !== !ack_last) begin
      fails++; $display("FAIL timeout_idle%0d: done %b mem_req %b err_to %b want 0000 0 %b", ack_last, done_o, mem_req_o, err_timeout_o, !ack_last);
    end
  endtask
  task automatic test_reset_mid;
    logic [22:0] got;
    do_reset;
    req_i = 4'hF; msg_i = 8'b01_01_01_11;
    repeat (7) cyc;
    checks++;
    if (mem_req_o !== 1'b1 || bus_owner_o !== 2'd1) begin
      fails++; $display("FAIL rstmid_pre: mem_req %b owner %0d want 1 1", mem_req_o, bus_owner_o);
    end
    rst_i = 1'b1;
    cyc;
    rst_i = 1'b0;
    got = {gnt_o, done_o, bus_valid_o, bus_msg_o, bus_addr_o, bus_owner_o, flush_o, mem_req_o, err_flush_o, err_timeout_o};
    checks++;
    if (got !== '0) begin fails++; $display("FAIL rstmid_outputs: got %h want 0", got); end
    cyc;
    checks++;
    if (gnt_o !== 4'b0001 || done_o !== 4'b0000) begin
      fails++; $display("FAIL rstmid_regrant: gnt %b done %b want 0001 0000", gnt_o, done_o);
    end
    req_i = '0;
  endtask
  initial begin
    test_reset;
    test_round_robin;
    test_flush_rdx;
    test_upgrade;
    test_multi_flush;
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
